// File: rtl/rv32_pkg.sv
// RV32I decode constants, ALU op encoding, control bundle and immediate helpers.
package rv32_pkg;

  localparam logic [6:0] OpcLui     = 7'b0110111;
  localparam logic [6:0] OpcAuipc   = 7'b0010111;
  localparam logic [6:0] OpcJal     = 7'b1101111;
  localparam logic [6:0] OpcJalr    = 7'b1100111;
  localparam logic [6:0] OpcBranch  = 7'b1100011;
  localparam logic [6:0] OpcLoad    = 7'b0000011;
  localparam logic [6:0] OpcStore   = 7'b0100011;
  localparam logic [6:0] OpcOpImm   = 7'b0010011;
  localparam logic [6:0] OpcOp      = 7'b0110011;
  localparam logic [6:0] OpcMiscMem = 7'b0001111;
  localparam logic [6:0] OpcSystem  = 7'b1110011;

  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3Slt    = 3'b010;
  localparam logic [2:0] F3Sltu   = 3'b011;
  localparam logic [2:0] F3Xor    = 3'b100;
  localparam logic [2:0] F3SrlSra = 3'b101;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd, AluPassB
  } alu_op_t;

  typedef struct packed {
    alu_op_t    alu_op;
    logic       alu_src_imm;
    logic       alu_src_pc;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] mem_size;
    logic       branch;
    logic       jump;
    logic       system;
  } ctrl_t;

  localparam ctrl_t CtrlNop = '0;

  function automatic logic [31:0] imm_i(logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(logic [31:0] ins);
    return {ins[31:12], 12'h000};
  endfunction

  function automatic logic [31:0] imm_j(logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  // alt selects SUB/SRA on the two funct3 codes that have an alternate form.
  function automatic alu_op_t alu_op_of(logic [2:0] f3, logic alt);
    unique case (f3)
      F3AddSub: return alt ? AluSub : AluAdd;
      F3Sll:    return AluSll;
      F3Slt:    return AluSlt;
      F3Sltu:   return AluSltu;
      F3Xor:    return AluXor;
      F3SrlSra: return alt ? AluSra : AluSrl;
      F3Or:     return AluOr;
      default:  return AluAnd;
    endcase
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file, two combinational read ports, one write port, x0 hardwired to zero.
module regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  i_raddr_a,
  input  logic [4:0]  i_raddr_b,
  output logic [31:0] o_rdata_a,
  output logic [31:0] o_rdata_b,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata
);

  logic [31:0] r_regs [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == 5'd0) ? 32'h0 : r_regs[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == 5'd0) ? 32'h0 : r_regs[i_raddr_b];

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: instruction decode, operand read with WB bypass, ID/EX pipeline register.
// JAL/JALR select the PC operand; the link value pc+4 is formed downstream.
module decode_stage import rv32_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_stall,
  input  logic        id_flush,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  input  logic        if_valid,
  input  logic        if_error,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [31:0] id_pc,
  output logic [4:0]  id_rs1,
  output logic [4:0]  id_rs2,
  output logic [4:0]  id_rd,
  output logic [31:0] id_rs1_data,
  output logic [31:0] id_rs2_data,
  output logic [31:0] id_imm,
  output ctrl_t       id_ctrl,
  output logic        id_valid,
  output logic        id_illegal,
  output logic        id_fetch_err
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [31:0] w_rf_rs1;
  logic [31:0] w_rf_rs2;
  logic [31:0] w_rs1_data;
  logic [31:0] w_rs2_data;
  logic [31:0] w_imm;
  logic        w_illegal;
  ctrl_t       w_ctrl;

  logic [31:0] r_pc;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [4:0]  r_rd;
  logic [31:0] r_rs1_data;
  logic [31:0] r_rs2_data;
  logic [31:0] r_imm;
  ctrl_t       r_ctrl;
  logic        r_valid;
  logic        r_illegal;
  logic        r_fetch_err;

  assign w_opcode = if_instr[6:0];
  assign w_funct3 = if_instr[14:12];
  assign w_funct7 = if_instr[31:25];
  assign w_rs1    = if_instr[19:15];
  assign w_rs2    = if_instr[24:20];

  regfile u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_raddr_a (w_rs1),
    .i_raddr_b (w_rs2),
    .o_rdata_a (w_rf_rs1),
    .o_rdata_b (w_rf_rs2),
    .i_we      (wb_we),
    .i_waddr   (wb_rd),
    .i_wdata   (wb_data)
  );

  // Write-through: a WB write on this edge is visible to the instruction being loaded.
  assign w_rs1_data = (wb_we && (wb_rd == w_rs1) && (w_rs1 != 5'd0)) ? wb_data : w_rf_rs1;
  assign w_rs2_data = (wb_we && (wb_rd == w_rs2) && (w_rs2 != 5'd0)) ? wb_data : w_rf_rs2;

  always_comb begin
    w_ctrl    = CtrlNop;
    w_imm     = '0;
    w_illegal = 1'b0;
    unique case (w_opcode)
      OpcLui: begin
        w_ctrl.alu_op      = AluPassB;
        w_ctrl.alu_src_imm = 1'b1;
        w_ctrl.reg_write   = 1'b1;
        w_imm              = imm_u(if_instr);
      end
      OpcAuipc: begin
        w_ctrl.alu_src_pc  = 1'b1;
        w_ctrl.alu_src_imm = 1'b1;
        w_ctrl.reg_write   = 1'b1;
        w_imm              = imm_u(if_instr);
      end
      OpcJal, OpcJalr: begin
        w_ctrl.alu_src_pc = 1'b1;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.jump       = 1'b1;
        w_imm             = (w_opcode == OpcJal) ? imm_j(if_instr) : imm_i(if_instr);
      end
      OpcBranch: begin
        w_ctrl.alu_op = AluSub;
        w_ctrl.branch = 1'b1;
        w_imm         = imm_b(if_instr);
        w_illegal     = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
      end
      OpcLoad: begin
        w_ctrl.alu_src_imm = 1'b1;
        w_ctrl.reg_write   = 1'b1;
        w_ctrl.mem_read    = 1'b1;
        w_ctrl.mem_size    = w_funct3;
        w_imm              = imm_i(if_instr);
        w_illegal          = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) ||
                             (w_funct3 == 3'b111);
      end
      OpcStore: begin
        w_ctrl.alu_src_imm = 1'b1;
        w_ctrl.mem_write   = 1'b1;
        w_ctrl.mem_size    = w_funct3;
        w_imm              = imm_s(if_instr);
        w_illegal          = (w_funct3 >= 3'b011);
      end
      OpcOpImm: begin
        w_ctrl.alu_op      = alu_op_of(w_funct3, (w_funct3 == F3SrlSra) && (w_funct7 == F7Alt));
        w_ctrl.alu_src_imm = 1'b1;
        w_ctrl.reg_write   = 1'b1;
        w_imm              = imm_i(if_instr);
        w_illegal          = ((w_funct3 == F3Sll) && (w_funct7 != F7Base)) ||
                             ((w_funct3 == F3SrlSra) && (w_funct7 != F7Base) &&
                              (w_funct7 != F7Alt));
      end
      OpcOp: begin
        w_ctrl.alu_op    = alu_op_of(w_funct3, w_funct7 == F7Alt);
        w_ctrl.reg_write = 1'b1;
        w_illegal        = !((w_funct7 == F7Base) ||
                             ((w_funct7 == F7Alt) &&
                              ((w_funct3 == F3AddSub) || (w_funct3 == F3SrlSra))));
      end
      OpcMiscMem: begin
        w_imm = imm_i(if_instr);
      end
      OpcSystem: begin
        w_ctrl.system = 1'b1;
        w_imm         = imm_i(if_instr);
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal || if_error) begin
      w_ctrl.reg_write = 1'b0;
      w_ctrl.mem_read  = 1'b0;
      w_ctrl.mem_write = 1'b0;
      w_ctrl.branch    = 1'b0;
      w_ctrl.jump      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_ctrl      <= CtrlNop;
      r_valid     <= 1'b0;
      r_illegal   <= 1'b0;
      r_fetch_err <= 1'b0;
    end else if (id_flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= CtrlNop;
    end else if (id_stall) begin
      // Held operands must track WB writes to their registers while stalled.
      if (wb_we && (wb_rd != 5'd0) && (wb_rd == r_rs1)) r_rs1_data <= wb_data;
      if (wb_we && (wb_rd != 5'd0) && (wb_rd == r_rs2)) r_rs2_data <= wb_data;
    end else begin
      r_pc        <= if_pc;
      r_rs1       <= w_rs1;
      r_rs2       <= w_rs2;
      r_rd        <= if_instr[11:7];
      r_rs1_data  <= w_rs1_data;
      r_rs2_data  <= w_rs2_data;
      r_imm       <= w_imm;
      r_ctrl      <= if_valid ? w_ctrl : CtrlNop;
      r_valid     <= if_valid;
      r_illegal   <= if_valid && w_illegal;
      r_fetch_err <= if_valid && if_error;
    end
  end

  assign id_pc        = r_pc;
  assign id_rs1       = r_rs1;
  assign id_rs2       = r_rs2;
  assign id_rd        = r_rd;
  assign id_rs1_data  = r_rs1_data;
  assign id_rs2_data  = r_rs2_data;
  assign id_imm       = r_imm;
  assign id_ctrl      = r_ctrl;
  assign id_valid     = r_valid;
  assign id_illegal   = r_illegal;
  assign id_fetch_err = r_fetch_err;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h00000000, reset value of id_pc.
REQ-002 SHALL have port: clk  in  1  system clock.
REQ-003 SHALL have port: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port: id_stall  in  1  hold ID/EX register (hazard unit).
REQ-005 SHALL have port: id_flush  in  1  squash ID/EX register (hazard unit).
REQ-006 SHALL have ports: if_pc  in  32, if_instr  in  32, if_valid  in  1, if_error  in  1, all from the fetch stage.
REQ-007 SHALL have ports: wb_we  in  1, wb_rd  in  5, wb_data  in  32, the writeback port.
REQ-008 SHALL have ports: id_pc  out  32, id_rs1/id_rs2/id_rd  out  5, id_rs1_data/id_rs2_data  out  32, id_imm  out  32.
REQ-009 SHALL have ports: id_ctrl  out  ctrl_t, the package control bundle; id_valid  out  1; id_illegal  out  1; id_fetch_err  out  1.

Function
REQ-010 SHALL register all id_* outputs on posedge clk; latency is 1 cycle from if_* to id_*.
REQ-011 SHALL give priority flush > stall > load; flush sets id_valid=0 and id_ctrl=0, and holds the other outputs.
REQ-012 SHALL, when stalled and not flushed, hold every output, except per REQ-019.
REQ-013 SHALL, when loading with if_valid=0, insert a bubble: id_valid=0, id_ctrl=0, id_illegal=0, id_fetch_err=0.
REQ-014 SHALL decode the RV32I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM and SYSTEM.
REQ-015 SHALL treat FENCE as NOP (ctrl zero, legal), and SHALL flag ECALL/EBREAK in id_ctrl.system.
REQ-016 SHALL set id_illegal=1 for any of:
- instr[1:0]!=2'b11
- unknown opcode
- BRANCH funct3 010/011
- LOAD funct3 011/110/111
- STORE funct3 >=011
- OP funct7 not 0000000, or 0100000 outside ADD/SRL
- SLLI/SRLI/SRAI with a bad funct7
An illegal instruction SHALL still assert id_valid but SHALL clear reg_write, mem_read, mem_write, branch and jump.
REQ-017 SHALL set id_fetch_err=if_error, suppressing the same controls as REQ-016.
REQ-018 SHALL generate I/S/B/U/J immediates sign-extended from instr[31]; id_imm SHALL be 0 for R-type.
REQ-019 SHALL, while stalled, overwrite held id_rs1_data (or id_rs2_data) with wb_data when wb_we and wb_rd==held id_rs1 (or id_rs2) and wb_rd!=0.
REQ-020 SHALL read register operands combinationally with write-through bypass: if wb_we and wb_rd==rs and rs!=0, the operand is wb_data.
REQ-021 SHALL hardwire x0 to zero; writes with wb_rd=0 are ignored.
REQ-022 SHALL encode id_ctrl.alu_op (4 bits) as ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B (LUI), with AUIPC/JAL/JALR selecting the PC operand via id_ctrl.alu_src_pc.
REQ-023 SHALL NOT stall on regfile writes; the WB write occurs on the same edge as the ID/EX load.

Reset
REQ-024 SHALL asynchronously set id_pc=RESET_PC and all other outputs to 0, including id_valid=0.
REQ-025 SHALL asynchronously clear all 31 writable registers to 0.
REQ-026 SHALL, on reset asserted mid-stall, discard the held instruction; the first post-reset cycle is a bubble.

Structure
REQ-027 SHALL import rv32_pkg, which holds the opcode/funct3/funct7 constants, alu_op_t, ctrl_t (alu_op, alu_src_imm, alu_src_pc, reg_write, mem_read, mem_write, mem_size[2:0], branch, jump, system) and the NOP encoding.
REQ-028 SHALL instantiate one sub-module, regfile, as a 32x32 2-read/1-write register file with async reset and x0 hardwired; bypass logic SHALL reside in decode_stage.

Verification
REQ-029 SHALL verify: if_instr=0x00500093 (addi x1,x0,5), if_pc=0x100, if_valid=1 -> next cycle id_valid=1, id_rd=1, id_imm=5, alu ADD, alu_src_imm=1, reg_write=1, id_pc=0x100.
REQ-030 SHALL verify: wb_we=1, wb_rd=3, wb_data=0xDEADBEEF in the same cycle as add x4,x3,x3 -> id_rs1_data=id_rs2_data=0xDEADBEEF.
REQ-031 SHALL verify: id_stall=1 for 3 cycles with held id_rs1=5, and WB writes x5=0x1234 in cycle 2 -> all outputs held except id_rs1_data=0x1234.
REQ-032 SHALL verify: id_flush=1 and id_stall=1 together -> next cycle id_valid=0 and id_ctrl=0.
REQ-033 SHALL verify: if_instr=0xFFFFFFFF -> id_illegal=1, reg_write=0; addi with if_error=1 -> id_fetch_err=1, reg_write=0.
REQ-034 SHALL verify: 0xFE000EE3 (beq x0,x0,-4) -> id_imm=0xFFFFFFFC, branch=1; wb_we=1 with wb_rd=0 -> x0 reads 0.
